ram_wb_bridge: RTL and testbench

RAM_WB_BRIDGE -- requirements
Module: ram_wb_bridge

---
 rtl/ram_wb_bridge_pkg.sv | 26 ++
 rtl/ram_burst_addr.sv | 30 +++
 rtl/ram_wb_bridge.sv | 132 +++++++++++++
 tb/tb_ram_wb_bridge.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_wb_bridge_pkg.sv
// ram_wb_bridge_pkg
// Shared encodings for the Wishbone-to-RAM bridge: Wishbone cycle-type
// (CTI) codes, burst-type (BTE) codes and the bridge FSM state encoding.
package ram_wb_bridge_pkg;

    // Wishbone cycle type identifiers used by the bridge
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Wishbone burst type extension
    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2
    } state_e;

endpackage

// File: rtl/ram_burst_addr.sv
// ram_burst_addr
// Computes the next word address of a Wishbone burst.
//   addr      : current RAM word address (byte address bits [31:2])
//   bte       : burst type; linear increments the SIZE-bit RAM word index,
//               wrap modes increment only the low 2/3/4 bits and wrap there
//   next_addr : following word address; bits not incremented are held
// SIZE must be at least 4 so that a 16-beat wrap fits inside the RAM index.
module ram_burst_addr
    import ram_wb_bridge_pkg::*;
#(
    parameter int SIZE = 14
) (
    input  logic [29:0] addr,
    input  logic [1:0]  bte,
    output logic [29:0] next_addr
);

    // Increment the field selected by the burst type, hold everything else
    always_comb begin
        next_addr = addr;
        case (bte)
            BTE_LINEAR: next_addr[SIZE-1:0] = addr[SIZE-1:0] + {{(SIZE-1){1'b0}}, 1'b1};
            BTE_WRAP4:  next_addr[1:0]      = addr[1:0] + 2'd1;
            BTE_WRAP8:  next_addr[2:0]      = addr[2:0] + 3'd1;
            BTE_WRAP16: next_addr[3:0]      = addr[3:0] + 4'd1;
            default:    next_addr           = addr;
        endcase
    end

endmodule

// File: rtl/ram_wb_bridge.sv
// ram_wb_bridge
// Wishbone B3 slave front-end for a single-port synchronous RAM whose read
// data appears one cycle after the enable. Classic cycles and writes take
// the SINGLE path (one ack, one idle cycle); incrementing read bursts
// prefetch one word ahead so an ack can be given every cycle.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   cyc_i, stb_i, we_i, addr_i, data_i, sel_i, cti_i, bte_i : Wishbone slave
//   data_o, ack_o                                           : Wishbone slave
//   ram_en_o, ram_we_o, ram_addr_o, ram_data_o, ram_data_i  : RAM port
module ram_wb_bridge
    import ram_wb_bridge_pkg::*;
#(
    parameter int SIZE = 14
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic [2:0]  cti_i,
    input  logic [1:0]  bte_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [29:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    state_e      state_r;
    state_e      state_next_s;
    logic        ack_q_r;
    logic        ack_q_next_s;
    logic [29:0] counter_r;
    logic [29:0] counter_next_s;
    logic [29:0] next_base_s;
    logic [29:0] next_addr_s;
    logic        ram_en_s;
    logic [3:0]  ram_we_s;
    logic [29:0] ram_addr_s;
    logic        req_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^addr_i[1:0];
    assign req_s         = cyc_i & stb_i;

    // In IDLE the prefetch starts from the incoming address, in BURST from the counter
    assign next_base_s = (state_r == ST_BURST) ? counter_r : addr_i[31:2];

    ram_burst_addr #(
        .SIZE (SIZE)
    ) u_burst_addr (
        .addr      (next_base_s),
        .bte       (bte_i),
        .next_addr (next_addr_s)
    );

    // FSM state, ack and burst address registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r   <= ST_IDLE;
            ack_q_r   <= 1'b0;
            counter_r <= 30'd0;
        end else begin
            state_r   <= state_next_s;
            ack_q_r   <= ack_q_next_s;
            counter_r <= counter_next_s;
        end
    end

    // Next-state logic and RAM access decode
    always_comb begin
        state_next_s   = state_r;
        ack_q_next_s   = ack_q_r;
        counter_next_s = counter_r;
        ram_en_s       = 1'b0;
        ram_we_s       = 4'b0000;
        ram_addr_s     = addr_i[31:2];
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    ram_en_s     = 1'b1;
                    ram_we_s     = we_i ? sel_i : 4'b0000;
                    ack_q_next_s = 1'b1;
                    // Bursts are read-only; an incrementing write is served as classic
                    if (!we_i && (cti_i == CTI_INCR)) begin
                        state_next_s   = ST_BURST;
                        counter_next_s = next_addr_s;
                    end else begin
                        state_next_s = ST_SINGLE;
                    end
                end else begin
                    ack_q_next_s = 1'b0;
                end
            end
            ST_SINGLE: begin
                state_next_s = ST_IDLE;
                ack_q_next_s = 1'b0;
            end
            ST_BURST: begin
                // Cycle drop, master wait and end-of-burst all leave the prefetch unused
                if (!cyc_i || !stb_i || (cti_i == CTI_END)) begin
                    state_next_s = ST_IDLE;
                    ack_q_next_s = 1'b0;
                end else begin
                    ram_en_s       = 1'b1;
                    ram_addr_s     = counter_r;
                    counter_next_s = next_addr_s;
                    ack_q_next_s   = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                ack_q_next_s = 1'b0;
            end
        endcase
    end

    // Reset forces the RAM port and ack quiet even while a request is presented
    assign ram_en_o   = ram_en_s & rst_i;
    assign ram_we_o   = ram_we_s & {4{rst_i}};
    assign ram_addr_o = ram_addr_s;
    assign ack_o      = ack_q_r & cyc_i & stb_i & rst_i;
    assign ram_data_o = data_i;
    assign data_o     = ram_data_i;

endmodule

// File: tb/tb_ram_wb_bridge.sv
// tb_ram_wb_bridge
// Directed bench for ram_wb_bridge. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge of the same cycle.
module tb_ram_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [29:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    int checks = 0;
    int errors = 0;

    ram_wb_bridge #(.SIZE(14)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .sel_i      (sel_i),
        .cti_i      (cti_i),
        .bte_i      (bte_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to the next cycle (just after the rising edge)
    task automatic go();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic bus(input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [2:0] ct, input logic [1:0] bt);
        cyc_i  = c;
        stb_i  = s;
        we_i   = w;
        addr_i = a;
        cti_i  = ct;
        bte_i  = bt;
    endtask

    // idle the bus for one cycle and confirm nothing is issued
    task automatic quiet(input string tag);
        go();
        bus(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        sample();
        chk({tag, "_en"}, {31'd0, ram_en_o}, 32'd0);
        chk({tag, "_ack"}, {31'd0, ack_o}, 32'd0);
    endtask

    initial begin
        rst_i      = 1'b0;
        data_i     = 32'h0;
        sel_i      = 4'hF;
        ram_data_i = 32'h0;
        // request presented while in reset must be ignored
        bus(1'b1, 1'b1, 1'b1, 32'h100, 3'b000, 2'b00);
        go();
        sample();
        chk("rst_en", {31'd0, ram_en_o}, 32'd0);
        chk("rst_we", {28'd0, ram_we_o}, 32'd0);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        go();
        rst_i = 1'b1;
        bus(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00);
        sample();
        chk("idle_en", {31'd0, ram_en_o}, 32'd0);

        // full-word write at 0x100, held for two back-to-back transfers
        go();
        bus(1'b1, 1'b1, 1'b1, 32'h100, 3'b000, 2'b00);
        data_i = 32'hDEADBEEF;
        sel_i  = 4'b1111;
        sample();
        chk("wr_we", {28'd0, ram_we_o}, 32'hF);
        chk("wr_addr", {2'd0, ram_addr_o}, 32'h40);
        chk("wr_en", {31'd0, ram_en_o}, 32'd1);
        chk("wr_data", ram_data_o, 32'hDEADBEEF);
        chk("wr_ack0", {31'd0, ack_o}, 32'd0);
        go();
        sample();
        chk("wr_ack1", {31'd0, ack_o}, 32'd1);
        chk("wr_en1", {31'd0, ram_en_o}, 32'd0);
        go();
        sample();
        chk("wr_ack2", {31'd0, ack_o}, 32'd0);
        chk("wr_we2", {28'd0, ram_we_o}, 32'hF);
        go();
        sample();
        chk("wr_ack3", {31'd0, ack_o}, 32'd1);
        quiet("wr_end");

        // byte-lane write then classic read of 0x104
        go();
        bus(1'b1, 1'b1, 1'b1, 32'h104, 3'b000, 2'b00);
        sel_i = 4'b0010;
        sample();
        chk("sw_we", {28'd0, ram_we_o}, 32'h2);
        chk("sw_addr", {2'd0, ram_addr_o}, 32'h41);
        go();
        sample();
        chk("sw_ack", {31'd0, ack_o}, 32'd1);
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h104, 3'b000, 2'b00);
        sample();
        chk("rd_en", {31'd0, ram_en_o}, 32'd1);
        chk("rd_we", {28'd0, ram_we_o}, 32'd0);
        chk("rd_addr", {2'd0, ram_addr_o}, 32'h41);
        chk("rd_ack0", {31'd0, ack_o}, 32'd0);
        go();
        ram_data_i = 32'h0000AB00;
        sample();
        chk("rd_ack1", {31'd0, ack_o}, 32'd1);
        chk("rd_data", data_o, 32'h0000AB00);
        quiet("rd_end");

        // incrementing write is served as a classic write
        go();
        bus(1'b1, 1'b1, 1'b1, 32'h300, 3'b010, 2'b00);
        sel_i = 4'b1111;
        sample();
        chk("iw_addr", {2'd0, ram_addr_o}, 32'hC0);
        go();
        sample();
        chk("iw_ack", {31'd0, ack_o}, 32'd1);
        chk("iw_en", {31'd0, ram_en_o}, 32'd0);
        quiet("iw_end");

        // linear burst at 0x200
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h200, 3'b010, 2'b00);
        sample();
        chk("lin_a0", {2'd0, ram_addr_o}, 32'h80);
        chk("lin_ack0", {31'd0, ack_o}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            go();
            sample();
            chk("lin_ack", {31'd0, ack_o}, 32'd1);
            chk("lin_en", {31'd0, ram_en_o}, 32'd1);
            chk("lin_addr", {2'd0, ram_addr_o}, 32'h80 + 32'(i));
        end
        go();
        cti_i = 3'b111;
        sample();
        chk("lin_last_ack", {31'd0, ack_o}, 32'd1);
        chk("lin_last_en", {31'd0, ram_en_o}, 32'd0);
        quiet("lin_end");

        // 4-beat wrap at 0x208: 82 83 80 81
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h208, 3'b010, 2'b01);
        sample();
        chk("w4_a0", {2'd0, ram_addr_o}, 32'h82);
        go();
        sample();
        chk("w4_a1", {2'd0, ram_addr_o}, 32'h83);
        go();
        sample();
        chk("w4_a2", {2'd0, ram_addr_o}, 32'h80);
        go();
        sample();
        chk("w4_a3", {2'd0, ram_addr_o}, 32'h81);
        chk("w4_ack3", {31'd0, ack_o}, 32'd1);
        go();
        cti_i = 3'b111;
        sample();
        chk("w4_last_ack", {31'd0, ack_o}, 32'd1);
        chk("w4_last_en", {31'd0, ram_en_o}, 32'd0);
        quiet("w4_end");

        // 8-beat wrap from word 0x87 wraps to 0x80
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h21C, 3'b010, 2'b10);
        sample();
        chk("w8_a0", {2'd0, ram_addr_o}, 32'h87);
        go();
        sample();
        chk("w8_a1", {2'd0, ram_addr_o}, 32'h80);
        go();
        cti_i = 3'b111;
        sample();
        chk("w8_last_en", {31'd0, ram_en_o}, 32'd0);
        quiet("w8_end");

        // linear carry stops at the RAM index width: word 0x7FFF -> 0x4000
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h0001FFFC, 3'b010, 2'b00);
        sample();
        chk("lc_a0", {2'd0, ram_addr_o}, 32'h7FFF);
        go();
        sample();
        chk("lc_a1", {2'd0, ram_addr_o}, 32'h4000);
        go();
        cti_i = 3'b111;
        sample();
        chk("lc_last_ack", {31'd0, ack_o}, 32'd1);
        quiet("lc_end");

        // master wait mid-burst, restart from 0x20C
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h200, 3'b010, 2'b00);
        sample();
        chk("mw_a0", {2'd0, ram_addr_o}, 32'h80);
        go();
        sample();
        chk("mw_a1", {2'd0, ram_addr_o}, 32'h81);
        go();
        sample();
        chk("mw_a2", {2'd0, ram_addr_o}, 32'h82);
        go();
        stb_i = 1'b0;
        sample();
        chk("mw_gap_ack", {31'd0, ack_o}, 32'd0);
        chk("mw_gap_en", {31'd0, ram_en_o}, 32'd0);
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h20C, 3'b010, 2'b00);
        sample();
        chk("mw_re_en", {31'd0, ram_en_o}, 32'd1);
        chk("mw_re_addr", {2'd0, ram_addr_o}, 32'h83);
        chk("mw_re_ack", {31'd0, ack_o}, 32'd0);
        go();
        sample();
        chk("mw_re_ack1", {31'd0, ack_o}, 32'd1);
        chk("mw_re_a1", {2'd0, ram_addr_o}, 32'h84);
        go();
        cti_i = 3'b111;
        sample();
        chk("mw_last_en", {31'd0, ram_en_o}, 32'd0);
        quiet("mw_end");

        // reset in beat 2 of a burst
        go();
        bus(1'b1, 1'b1, 1'b0, 32'h200, 3'b010, 2'b00);
        sample();
        chk("rb_a0", {2'd0, ram_addr_o}, 32'h80);
        go();
        sample();
        chk("rb_ack1", {31'd0, ack_o}, 32'd1);
        go();
        rst_i = 1'b0;
        sample();
        chk("rb_rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rb_rst_en", {31'd0, ram_en_o}, 32'd0);
        go();
        sample();
        chk("rb_after_ack", {31'd0, ack_o}, 32'd0);
        chk("rb_after_en", {31'd0, ram_en_o}, 32'd0);
        go();
        rst_i = 1'b1;
        sample();
        chk("rb_rel_en", {31'd0, ram_en_o}, 32'd1);
        chk("rb_rel_addr", {2'd0, ram_addr_o}, 32'h80);
        chk("rb_rel_ack", {31'd0, ack_o}, 32'd0);
        go();
        cti_i = 3'b111;
        sample();
        chk("rb_last_ack", {31'd0, ack_o}, 32'd1);
        quiet("rb_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
